// File: rtl/rca_nibble_sequencer.sv
// Wide adder/subtractor that reuses one 4-bit ripple-carry adder across the operand
// nibbles, LSB first, with valid/ready handshakes on the request and result sides.

module ripple_carry_adder (
   input  logic [3:0] x,
   input  logic [3:0] y,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);
   logic [4:0] c;

   assign c[0] = ci;

   genvar i;
   generate
      for (i = 0; i < 4; i++) begin : g_fa
         assign s[i]   = x[i] ^ y[i] ^ c[i];
         assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
      end
   endgenerate

   assign co = c[4];
endmodule

// state | meaning
// IDLE  | waiting for a request, start_ready high, last result held
// RUN   | one nibble per clock through the shared adder, index k
// DONE  | result presented with done_valid until done_ready
module rca_nibble_sequencer #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start_valid,
   output logic                   start_ready,
   input  logic [4*NIBBLES-1:0]   a,
   input  logic [4*NIBBLES-1:0]   b,
   input  logic                   cin,
   input  logic                   sub,
   output logic [4*NIBBLES-1:0]   sum,
   output logic                   cout,
   output logic                   overflow,
   output logic                   done_valid,
   input  logic                   done_ready,
   output logic                   busy
);
   localparam int W  = 4 * NIBBLES;
   localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [W-1:0]  a_q;
   logic [W-1:0]  b_q;
   logic          carry_q;
   logic [KW-1:0] k;
   logic [W-1:0]  sum_q;
   logic          cout_q;
   logic          ovf_q;

   logic [3:0]    a_nib;
   logic [3:0]    b_nib;
   logic [3:0]    nib_sum;
   logic          nib_co;
   logic          last;
   logic          accept;

   assign a_nib  = a_q[{k, 2'b00} +: 4];
   assign b_nib  = b_q[{k, 2'b00} +: 4];
   assign last   = (k == KW'(NIBBLES - 1));
   assign accept = (state == IDLE) && start_valid;

   ripple_carry_adder u_rca (
      .x  (a_nib),
      .y  (b_nib),
      .ci (carry_q),
      .s  (nib_sum),
      .co (nib_co)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_valid) state_nxt = RUN;
         RUN:     if (last)        state_nxt = DONE;
         DONE:    if (done_ready)  state_nxt = IDLE;
         default:                  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         k       <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (accept) begin
         a_q     <= a;
         b_q     <= sub ? ~b : b;
         carry_q <= sub | cin;
         k       <= '0;
      end else if (state == RUN) begin
         for (int i = 0; i < NIBBLES; i++) begin
            if (k == KW'(i)) sum_q[4*i +: 4] <= nib_sum;
         end
         carry_q <= nib_co;
         if (last) begin
            cout_q <= nib_co;
            // carry into the MSB is recovered from the MSB's sum bit
            ovf_q  <= a_q[W-1] ^ b_q[W-1] ^ nib_sum[3] ^ nib_co;
         end else begin
            k <= k + KW'(1);
         end
      end
   end

   assign sum         = sum_q;
   assign cout        = cout_q;
   assign overflow    = ovf_q;
   assign start_ready = (state == IDLE);
   assign done_valid  = (state == DONE);
   assign busy        = (state != IDLE);
endmodule

// File: tb/tb_rca_nibble_sequencer.sv
// Bench for rca_nibble_sequencer: directed cases with literal results plus random
// traffic, all compared each cycle against an arithmetic reference of the handshake.

module tb_rca_nibble_sequencer;
   localparam int NIB = 4;
   localparam int W   = 4 * NIB;

   logic         clk;
   logic         rst;
   logic         start_valid;
   logic         start_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         sub;
   logic [W-1:0] sum;
   logic         cout;
   logic         overflow;
   logic         done_valid;
   logic         done_ready;
   logic         busy;

   int errors = 0;
   int checks = 0;

   rca_nibble_sequencer #(.NIBBLES(NIB)) dut (
      .clk         (clk),
      .rst         (rst),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .a           (a),
      .b           (b),
      .cin         (cin),
      .sub         (sub),
      .sum         (sum),
      .cout        (cout),
      .overflow    (overflow),
      .done_valid  (done_valid),
      .done_ready  (done_ready),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // reference: whole-word arithmetic plus a latency count since accept
   logic         m_valid = 1'b0;
   logic         m_busy  = 1'b0;
   logic         m_done  = 1'b0;
   int           m_cnt   = 0;
   logic [W-1:0] m_sum   = '0;
   logic         m_cout  = 1'b0;
   logic         m_ovf   = 1'b0;
   logic [W-1:0] p_sum;
   logic         p_cout;
   logic         p_ovf;

   always @(posedge clk) begin
      logic [W-1:0] bp;
      logic [W:0]   t;
      if (rst) begin
         m_valid = 1'b1;
         m_busy  = 1'b0;
         m_done  = 1'b0;
         m_cnt   = 0;
         m_sum   = '0;
         m_cout  = 1'b0;
         m_ovf   = 1'b0;
      end else if (!m_busy) begin
         if (start_valid) begin
            bp     = sub ? ~b : b;
            t      = {1'b0, a} + {1'b0, bp} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
            p_sum  = t[W-1:0];
            p_cout = t[W];
            p_ovf  = (a[W-1] == bp[W-1]) && (t[W-1] != a[W-1]);
            m_busy = 1'b1;
            m_cnt  = 0;
         end
      end else if (!m_done) begin
         m_cnt++;
         if (m_cnt == NIB) begin
            m_done = 1'b1;
            m_sum  = p_sum;
            m_cout = p_cout;
            m_ovf  = p_ovf;
         end
      end else if (done_ready) begin
         m_busy = 1'b0;
         m_done = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("start_ready", start_ready, !m_busy);
         chk("busy", busy, m_busy);
         chk("done_valid", done_valid, m_done);
         if (m_done || !m_busy) begin
            chk("sum", sum, m_sum);
            chk("cout", cout, m_cout);
            chk("overflow", overflow, m_ovf);
         end
      end
   end

   task automatic run_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic tcin, input logic tsub, input logic [W-1:0] es,
                         input logic ec, input logic eo, input int hold);
      int n;
      @(negedge clk);
      chk({nm, " start_ready"}, start_ready, 1'b1);
      a = ta; b = tb_v; cin = tcin; sub = tsub; start_valid = 1'b1; done_ready = 1'b0;
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done_valid && n < 20);
      chk({nm, " latency"}, n, NIB + 1);
      chk({nm, " sum"}, sum, es);
      chk({nm, " cout"}, cout, ec);
      chk({nm, " overflow"}, overflow, eo);
      for (int i = 0; i < hold; i++) begin
         start_valid = ~start_valid;
         a = W'($urandom);
         @(negedge clk);
         chk({nm, " hold done_valid"}, done_valid, 1'b1);
         chk({nm, " hold sum"}, sum, es);
         chk({nm, " hold cout"}, cout, ec);
         chk({nm, " hold start_ready"}, start_ready, 1'b0);
      end
      start_valid = 1'b0;
      done_ready  = 1'b1;
      @(negedge clk);
      done_ready = 1'b0;
      chk({nm, " release start_ready"}, start_ready, 1'b1);
      chk({nm, " release busy"}, busy, 1'b0);
   endtask

   initial begin
      rst = 1'b1; start_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; done_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("reset sum", sum, 16'h0000);
      chk("reset start_ready", start_ready, 1'b1);
      chk("reset busy", busy, 1'b0);
      chk("reset done_valid", done_valid, 1'b0);

      run_op("plain add",  16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 0);
      run_op("carry ffff", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
      run_op("cin only",   16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 0);
      run_op("signed ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
      run_op("sub borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0);
      run_op("backpress",  16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 3);

      @(negedge clk);
      a = 16'hABCD; b = 16'h1111; cin = 1'b0; sub = 1'b0; start_valid = 1'b1;
      @(posedge clk);
      #1 start_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst sum", sum, 16'h0000);
      chk("midrst cout", cout, 1'b0);
      chk("midrst done_valid", done_valid, 1'b0);
      chk("midrst busy", busy, 1'b0);
      chk("midrst start_ready", start_ready, 1'b1);
      run_op("after rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 0);

      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         start_valid = ($urandom_range(0, 2) != 0);
         case ($urandom_range(0, 3))
            0:       a = 16'hFFFF;
            1:       a = 16'h8000;
            default: a = W'($urandom);
         endcase
         b          = ($urandom_range(0, 4) == 0) ? 16'h0001 : W'($urandom);
         cin        = 1'($urandom);
         sub        = 1'($urandom);
         done_ready = ($urandom_range(0, 3) != 0);
      end
      start_valid = 1'b0;
      done_ready  = 1'b1;
      repeat (NIB + 4) @(negedge clk);
      chk("drain busy", busy, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
